// File: rtl/bc_buffer_pkg.sv
// bc_buffer shared types and defaults.
// Optional build macro: BC_BUFFER_CLEAR_ON_IDLE_EN.
package bc_buffer_pkg;

   localparam int WIDTH_DEFAULT = 16;
   localparam int DEPTH_DEFAULT = 16;

   typedef logic [WIDTH_DEFAULT-1:0] word_t;

endpackage

// File: rtl/bc_fifo.sv
// One bc_buffer lane: circular store, pointers, count, registered output.
// BC_BUFFER_CLEAR_ON_IDLE_EN: output returns to 0 on any edge without a pop.
module bc_fifo
   import bc_buffer_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             empty;
   logic             full;
   logic             push_ok;
   logic             pop_ok;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign pop_ok  = rd_en && !empty;
   // A pop on a full lane frees the slot the push reuses.
   assign push_ok = wr_en && (!full || pop_ok);

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         unique case ({push_ok, pop_ok})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data <= '0;
      end else if (pop_ok) begin
         rd_data <= mem[rd_ptr];
      end else begin
`ifdef BC_BUFFER_CLEAR_ON_IDLE_EN
         rd_data <= '0;
`else
         rd_data <= rd_data;
`endif
      end
   end

endmodule

// File: rtl/bc_buffer.sv
// Two independent FIFO lanes between control and avoidance subsystems.
// Optional build macro: BC_BUFFER_CLEAR_ON_IDLE_EN (see bc_fifo).
module bc_buffer
   import bc_buffer_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ctrl_in_valid,
   input  logic [WIDTH-1:0] ctrl_in_data,
   input  logic             avoid_out_rdy,
   output logic [WIDTH-1:0] ctrl_out_data,
   input  logic             avoid_in_valid,
   input  logic [WIDTH-1:0] avoid_in_data,
   input  logic             ctrl_out_rdy,
   output logic [WIDTH-1:0] avoid_out_data
);

   // Control -> avoidance lane.
   bc_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ctrl_lane (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (ctrl_in_valid),
      .wr_data (ctrl_in_data),
      .rd_en   (avoid_out_rdy),
      .rd_data (ctrl_out_data)
   );

   // Avoidance -> control lane.
   bc_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_avoid_lane (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (avoid_in_valid),
      .wr_data (avoid_in_data),
      .rd_en   (ctrl_out_rdy),
      .rd_data (avoid_out_data)
   );

endmodule

// File: tb/tb_bc_buffer.sv
// Randomized self-checking bench for bc_buffer.
// Lanes are modelled as queues of words.
module tb_bc_buffer;
   import bc_buffer_pkg::*;

   localparam int DEPTH = DEPTH_DEFAULT;

   logic  clk = 1'b0;
   logic  rst = 1'b0;
   logic  ctrl_in_valid = 1'b0;
   word_t ctrl_in_data = '0;
   logic  avoid_out_rdy = 1'b0;
   word_t ctrl_out_data;
   logic  avoid_in_valid = 1'b0;
   word_t avoid_in_data = '0;
   logic  ctrl_out_rdy = 1'b0;
   word_t avoid_out_data;

   int total = 0;
   int bad = 0;

   word_t cq[$];
   word_t aq[$];
   word_t c_exp = '0;
   word_t a_exp = '0;

   always #5 clk = ~clk;

   bc_buffer dut (
      .clk            (clk),
      .rst            (rst),
      .ctrl_in_valid  (ctrl_in_valid),
      .ctrl_in_data   (ctrl_in_data),
      .avoid_out_rdy  (avoid_out_rdy),
      .ctrl_out_data  (ctrl_out_data),
      .avoid_in_valid (avoid_in_valid),
      .avoid_in_data  (avoid_in_data),
      .ctrl_out_rdy   (ctrl_out_rdy),
      .avoid_out_data (avoid_out_data)
   );

   task automatic check(input string tag, input word_t got, input word_t exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Queue semantics: pop first, then push if room (covers full push+pop).
   task automatic lane_model(inout word_t q[$], inout word_t out,
                             input logic v, input word_t d, input logic r);
      logic popped;
      popped = 1'b0;
      if (r && q.size() > 0) begin
         out = q.pop_front();
         popped = 1'b1;
      end
`ifdef BC_BUFFER_CLEAR_ON_IDLE_EN
      if (!popped) out = '0;
`endif
      if (v && q.size() < DEPTH) q.push_back(d);
   endtask

   task automatic step(input logic cv, input word_t cd, input logic ar,
                       input logic av, input word_t ad, input logic cr);
      ctrl_in_valid  = cv;
      ctrl_in_data   = cd;
      avoid_out_rdy  = ar;
      avoid_in_valid = av;
      avoid_in_data  = ad;
      ctrl_out_rdy   = cr;
      @(posedge clk);
      lane_model(cq, c_exp, cv, cd, ar);
      lane_model(aq, a_exp, av, ad, cr);
      @(negedge clk);
      check("ctrl_out", ctrl_out_data, c_exp);
      check("avoid_out", avoid_out_data, a_exp);
   endtask

   task automatic do_reset();
      ctrl_in_valid  = 1'b0;
      avoid_out_rdy  = 1'b0;
      avoid_in_valid = 1'b0;
      ctrl_out_rdy   = 1'b0;
      rst = 1'b0;
      cq.delete();
      aq.delete();
      c_exp = '0;
      a_exp = '0;
      #1;
      check("rst_async_ctrl", ctrl_out_data, 16'h0);
      check("rst_async_avoid", avoid_out_data, 16'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      @(negedge clk);
      do_reset();
      // Pops on empty lanes leave outputs 0.
      step(0, 0, 1, 0, 0, 1);
      check("rst_pop_ctrl", ctrl_out_data, 16'h0);
      check("rst_pop_avoid", avoid_out_data, 16'h0);

      // Control lane ordered sequence.
      for (int i = 0; i < 10; i++) step(1, word_t'(10 + i), 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 1, 0, 0, 0);
         check("ctrl_seq", ctrl_out_data, word_t'(10 + i));
      end
      step(0, 0, 1, 0, 0, 0);

      // Avoidance lane fill, overflow drop, drain.
      for (int i = 0; i < 16; i++) step(0, 0, 0, 1, word_t'(16'hA000 + i), 0);
      step(0, 0, 0, 1, 16'hBEEF, 0);
      for (int i = 0; i < 17; i++) begin
         step(0, 0, 0, 0, 0, 1);
         check("no_beef", word_t'(avoid_out_data == 16'hBEEF), 16'h0);
         if (i < 16) check("avoid_seq", avoid_out_data, word_t'(16'hA000 + i));
      end

      // Full lane with simultaneous push and pop.
      do_reset();
      for (int i = 0; i < 16; i++) step(1, word_t'(16'h0100 + i), 0, 0, 0, 0);
      step(1, 16'h5555, 1, 0, 0, 0);
      check("full_pp_first", ctrl_out_data, 16'h0100);
      for (int i = 1; i < 16; i++) begin
         step(0, 0, 1, 0, 0, 0);
         check("full_pp_rest", ctrl_out_data, word_t'(16'h0100 + i));
      end
      step(0, 0, 1, 0, 0, 0);
      check("full_pp_new", ctrl_out_data, 16'h5555);

      // Concurrent random traffic on both lanes with wrap-around.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, word_t'($urandom),
              $urandom_range(0, 2) != 0,
              $urandom_range(0, 2) != 0, word_t'($urandom),
              $urandom_range(0, 3) != 0);
      end
      for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 1, 0, 0, 1);
      check("ctrl_drained", word_t'(cq.size()), 16'h0);
      check("avoid_drained", word_t'(aq.size()), 16'h0);

      // Reset discards queued words.
      for (int i = 0; i < 5; i++) step(1, word_t'(16'h0700 + i), 0, 0, 0, 0);
      do_reset();
      step(0, 0, 1, 0, 0, 1);
      check("midrst_ctrl", ctrl_out_data, 16'h0);
      check("midrst_avoid", avoid_out_data, 16'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
